// File: rtl/butterfly_stage.sv
// Radix-2 DIT butterfly, three register stages with AXI-Stream style handshake.
//   y0 = x0 + W*x1, y1 = x0 - W*x1, then arithmetic >> SHIFT.
// Optional feature macro: BUTTERFLY_ROUND_EN (round half-up on both right
// shifts; when undefined both shifts truncate toward minus infinity).
// A frame counter flags any tlast that is not on word FRAME_LEN-1 (sticky).
module butterfly_stage #(
    parameter int WIDTH     = 9,
    parameter int TWIDWIDTH = 16,
    parameter int SHIFT     = 1,
    parameter int FRAME_LEN = 4,
    localparam int OUTW     = WIDTH + 2 - SHIFT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [4*WIDTH-1:0]     data_i,
    input  logic [2*TWIDWIDTH-1:0] twiddle_i,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [4*OUTW-1:0]      data_o,
    output logic                   frame_err
);

    localparam int PW = WIDTH + TWIDWIDTH;   // product width
    localparam int TW = PW + 2;              // twiddle sum plus rounding headroom
    localparam int SW = WIDTH + 3;           // x0 +/- t plus rounding headroom
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
`ifdef BUTTERFLY_ROUND_EN
    localparam logic signed [TW-1:0] RND2 = TW'((2 ** (TWIDWIDTH - 1)) / 2);
    localparam logic signed [SW-1:0] RND3 = SW'((2 ** SHIFT) / 2);
`endif

    logic en, accept;
    assign en            = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = rstn & en;
    assign accept        = s_axis_tvalid & s_axis_tready;

    logic signed [WIDTH-1:0]     x0r_in, x0i_in, x1r_in, x1i_in;
    logic signed [TWIDWIDTH-1:0] wr_in, wi_in;
    assign {x0r_in, x0i_in, x1r_in, x1i_in} = data_i;
    assign {wr_in, wi_in}                   = twiddle_i;

    logic                    v1, l1, v2, l2, v3, l3;
    logic signed [WIDTH-1:0] x0r1, x0i1, x0r2, x0i2;
    logic signed [PW-1:0]    pr1, pr2, pi1, pi2;
    logic signed [WIDTH+1:0] tr2, ti2;
    logic signed [OUTW-1:0]  y0r3, y0i3, y1r3, y1i3;
    logic [CW-1:0]           cnt;

    // Stage 1: four partial products, x0 travels alongside
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            l1   <= 1'b0;
            x0r1 <= '0;
            x0i1 <= '0;
            pr1  <= '0;
            pr2  <= '0;
            pi1  <= '0;
            pi2  <= '0;
        end else if (en) begin
            v1   <= accept;
            l1   <= s_axis_tlast & accept;
            x0r1 <= x0r_in;
            x0i1 <= x0i_in;
            pr1  <= PW'(x1r_in) * PW'(wr_in);
            pr2  <= PW'(x1i_in) * PW'(wi_in);
            pi1  <= PW'(x1r_in) * PW'(wi_in);
            pi2  <= PW'(x1i_in) * PW'(wr_in);
        end
    end

    logic signed [TW-1:0]    tr_sum, ti_sum, tr_sh, ti_sh;
    logic signed [WIDTH+1:0] tr_n, ti_n;
    logic                    fit2;

    // Stage 2 combinational: complex sum, scale the Q1.x twiddle back out
    always_comb begin
        tr_sum = TW'(pr1) - TW'(pr2);
        ti_sum = TW'(pi1) + TW'(pi2);
`ifdef BUTTERFLY_ROUND_EN
        tr_sum = tr_sum + RND2;
        ti_sum = ti_sum + RND2;
`endif
        tr_sh  = tr_sum >>> (TWIDWIDTH - 1);
        ti_sh  = ti_sum >>> (TWIDWIDTH - 1);
        tr_n   = tr_sh[WIDTH+1:0];
        ti_n   = ti_sh[WIDTH+1:0];
        fit2   = (tr_sh == TW'(tr_n)) && (ti_sh == TW'(ti_n));
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2   <= 1'b0;
            l2   <= 1'b0;
            x0r2 <= '0;
            x0i2 <= '0;
            tr2  <= '0;
            ti2  <= '0;
        end else if (en) begin
            v2   <= v1;
            l2   <= l1;
            x0r2 <= x0r1;
            x0i2 <= x0i1;
            tr2  <= tr_n;
            ti2  <= ti_n;
        end
    end

    function automatic logic signed [SW-1:0] scale_out(input logic signed [SW-1:0] v);
`ifdef BUTTERFLY_ROUND_EN
        return (v + RND3) >>> SHIFT;
`else
        return v >>> SHIFT;
`endif
    endfunction

    logic signed [SW-1:0]   s0r, s0i, s1r, s1i, h0r, h0i, h1r, h1i;
    logic signed [OUTW-1:0] y0r_n, y0i_n, y1r_n, y1i_n;
    logic                   fit3;

    // Stage 3 combinational: add/subtract, output scaling
    always_comb begin
        s0r   = SW'(x0r2) + SW'(tr2);
        s0i   = SW'(x0i2) + SW'(ti2);
        s1r   = SW'(x0r2) - SW'(tr2);
        s1i   = SW'(x0i2) - SW'(ti2);
        h0r   = scale_out(s0r);
        h0i   = scale_out(s0i);
        h1r   = scale_out(s1r);
        h1i   = scale_out(s1i);
        y0r_n = h0r[OUTW-1:0];
        y0i_n = h0i[OUTW-1:0];
        y1r_n = h1r[OUTW-1:0];
        y1i_n = h1i[OUTW-1:0];
        fit3  = (s0r[SW-1] == s0r[SW-2]) && (s0i[SW-1] == s0i[SW-2]) &&
                (s1r[SW-1] == s1r[SW-2]) && (s1i[SW-1] == s1i[SW-2]) &&
                (h0r == SW'(y0r_n)) && (h0i == SW'(y0i_n)) &&
                (h1r == SW'(y1r_n)) && (h1i == SW'(y1i_n));
    end

    // Stage 3 register drives the master side directly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3   <= 1'b0;
            l3   <= 1'b0;
            y0r3 <= '0;
            y0i3 <= '0;
            y1r3 <= '0;
            y1i3 <= '0;
        end else if (en) begin
            v3   <= v2;
            l3   <= l2;
            y0r3 <= y0r_n;
            y0i3 <= y0i_n;
            y1r3 <= y1r_n;
            y1i3 <= y1i_n;
        end
    end

    assign m_axis_tvalid = v3;
    assign m_axis_tlast  = l3;
    assign data_o        = {y0r3, y0i3, y1r3, y1i3};

    // Frame position tracking; tlast must land exactly on the last word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast != (cnt == LAST_CNT))
                frame_err <= 1'b1;
            cnt <= (s_axis_tlast || cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        end
    end

    // Bounded |W| keeps results inside the kept widths; dropped MSBs are sign copies
    assert property (@(posedge clk) disable iff (!rstn) (v1 && en) |-> fit2);
    assert property (@(posedge clk) disable iff (!rstn) (v2 && en) |-> fit3);

endmodule

// File: tb/tb_butterfly_stage.sv
module tb_butterfly_stage;

    localparam int OW  = 10;
    localparam int OW0 = 11;
`ifdef BUTTERFLY_ROUND_EN
    localparam int T1_Y0R = 82;
`else
    localparam int T1_Y0R = 81;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            s_valid, s_ready, s_last, m_valid, m_ready, m_last, ferr;
    logic [35:0]     data_i;
    logic [31:0]     tw;
    logic [4*OW-1:0] data_o;
    logic            s0_valid, s0_ready, s0_last, m0_valid, m0_ready, m0_last, ferr0;
    logic [35:0]     d0_i;
    logic [31:0]     tw0;
    logic [4*OW0-1:0] d0_o;

    butterfly_stage dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .data_i(data_i), .twiddle_i(tw),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
        .data_o(data_o), .frame_err(ferr)
    );

    butterfly_stage #(.SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready), .s_axis_tlast(s0_last),
        .data_i(d0_i), .twiddle_i(tw0),
        .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready), .m_axis_tlast(m0_last),
        .data_o(d0_o), .frame_err(ferr0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Floor shift, optionally rounding half-up first
    function automatic longint scl(input longint v, input int n);
        longint r;
        r = v;
`ifdef BUTTERFLY_ROUND_EN
        if (n > 0) r = r + (longint'(1) <<< (n - 1));
`endif
        return r >>> n;
    endfunction

    function automatic void bfly(input int x0r, x0i, x1r, x1i, wr, wi, sh,
                                 output int y0r, y0i, y1r, y1i);
        longint tr, ti;
        tr  = scl(longint'(x1r) * wr - longint'(x1i) * wi, 15);
        ti  = scl(longint'(x1r) * wi + longint'(x1i) * wr, 15);
        y0r = int'(scl(x0r + tr, sh));
        y0i = int'(scl(x0i + ti, sh));
        y1r = int'(scl(x0r - tr, sh));
        y1i = int'(scl(x0i - ti, sh));
    endfunction

    function automatic logic [35:0] px(input int a, b, c, d);
        return {9'(a), 9'(b), 9'(c), 9'(d)};
    endfunction
    function automatic logic [31:0] pw(input int a, b);
        return {16'(a), 16'(b)};
    endfunction
    function automatic logic [4*OW-1:0] py(input int a, b, c, d);
        return {10'(a), 10'(b), 10'(c), 10'(d)};
    endfunction

    function automatic void vec(input int i, output logic [35:0] d, output logic [31:0] w);
        d = px((i * 53) % 512 - 256, (i * 29 + 7) % 512 - 256,
               (i * 71 + 100) % 512 - 256, (i * 17 + 200) % 512 - 256);
        case (i % 4)
            0: w = pw(32767, 0);
            1: w = pw(0, -32768);
            2: w = pw(23170, -23170);
            default: w = pw(-32768, -32768);
        endcase
    endfunction

    // Scoreboard and frame model, all evaluated away from the rising edge
    logic [4*OW:0]   q[$];
    int              err_m = 0, pos_m = 0, n_out = 0;
    bit              prev_stall = 0;
    logic [4*OW-1:0] prev_d;
    logic            prev_l;

    always @(negedge clk) begin : cmp
        int y0r, y0i, y1r, y1i;
        logic [4*OW:0] ex;
        if (!rstn) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_data", data_o, 0);
            chk("rst_frame_err", ferr, 0);
            q.delete();
            err_m = 0;
            pos_m = 0;
            prev_stall = 0;
        end else begin
            chk("frame_err", ferr, err_m);
            chk("s_ready", s_ready, !(m_valid && !m_ready));
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", data_o, prev_d);
                chk("stall_last", m_last, prev_l);
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got output %0h, expected none", data_o);
                end else begin
                    ex = q.pop_front();
                    chk("out_data", data_o, ex[4*OW-1:0]);
                    chk("out_last", m_last, ex[4*OW]);
                    n_out++;
                end
            end
            if (s_valid && s_ready) begin
                bfly(int'($signed(data_i[35:27])), int'($signed(data_i[26:18])),
                     int'($signed(data_i[17:9])), int'($signed(data_i[8:0])),
                     int'($signed(tw[31:16])), int'($signed(tw[15:0])), 1,
                     y0r, y0i, y1r, y1i);
                q.push_back({s_last, py(y0r, y0i, y1r, y1i)});
                if (s_last != (pos_m == 3)) err_m = 1;
                pos_m = (s_last || pos_m == 3) ? 0 : pos_m + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = data_o;
            prev_l     = m_last;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic send(input logic [35:0] d, input logic [31:0] w, input logic last,
                        input string nm);
        bit hs;
        hs      = 0;
        data_i  = d;
        tw      = w;
        s_last  = last;
        s_valid = 1'b1;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            hs = s_ready;
            cyc();
        end
        s_valid = 1'b0;
        chk({nm, "_handshake"}, hs, 1);
    endtask

    task automatic send_lat(input logic [35:0] d, input logic [31:0] w, input logic last,
                            input logic [4*OW-1:0] exp, input bit has_exp, input string nm);
        send(d, w, last, nm);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s_valid_c%0d", nm, k), m_valid, (k == 3));
            if (k == 3 && has_exp) chk({nm, "_data"}, data_o, exp);
            cyc();
        end
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 30 && q.size() != 0; k++) cyc();
        chk({nm, "_drain"}, q.size(), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1);
    end

    initial begin
        logic [35:0] d;
        logic [31:0] w;
        int i, c, n0, y0r, y0i, y1r, y1i;
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        data_i = '0; tw = '0;
        s0_valid = 1'b0; s0_last = 1'b0; m0_ready = 1'b1; d0_i = '0; tw0 = '0;
        do_reset();

        // Test 1: real twiddle just below 1
        send_lat(px(100, 0, 64, 0), pw(32767, 0), 1'b0, py(T1_Y0R, 0, 18, 0), 1, "t1");
        // Test 2: W = -j
        send_lat(px(100, 0, 64, 0), pw(0, -32768), 1'b0, py(50, -32, 50, 32), 1, "t2");
        drain("t2");

        // Test 3: SHIFT=0 corner, W = (-1,-1)
        s0_valid = 1'b1; s0_last = 1'b0;
        d0_i = px(-256, -256, -256, -256);
        tw0  = pw(-32768, -32768);
        @(negedge clk);
        chk("t3_handshake", s0_ready, 1);
        cyc();
        s0_valid = 1'b0;
        repeat (2) begin @(negedge clk); cyc(); end
        @(negedge clk);
        chk("t3_valid", m0_valid, 1);
        chk("t3_data", d0_o, {11'(-256), 11'(256), 11'(-256), 11'(-768)});
        bfly(-256, -256, -256, -256, -32768, -32768, 0, y0r, y0i, y1r, y1i);
        chk("t3_model", d0_o, {11'(y0r), 11'(y0i), 11'(y1r), 11'(y1i)});
        chk("t3_last", m0_last, 0);
        chk("t3_frame_err", ferr0, 0);
        cyc();

        // Test 4: 16 back-to-back words, sink stalls on cycles 4..8
        do_reset();
        n0 = n_out;
        i = 0;
        c = 0;
        while (i < 16 && c < 100) begin
            vec(i, d, w);
            data_i  = d;
            tw      = w;
            s_last  = (i % 4 == 3);
            s_valid = 1'b1;
            m_ready = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (s_ready) i++;
            cyc();
            c++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("t4_inputs_accepted", i, 16);
        drain("t4");
        chk("t4_out_count", n_out - n0, 16);

        // Test 5: frame checking, then sticky error
        do_reset();
        for (int k = 0; k < 8; k++) begin
            vec(k, d, w);
            send(d, w, (k % 4 == 3), "t5_good");
        end
        chk("t5_no_err", ferr, 0);
        vec(8, d, w);
        send(d, w, 1'b0, "t5_w8");
        vec(9, d, w);
        send(d, w, 1'b1, "t5_w9");
        chk("t5_err_set", ferr, 1);
        for (int k = 10; k < 18; k++) begin
            vec(k, d, w);
            send(d, w, ((k - 10) % 4 == 3), "t5_after");
        end
        chk("t5_err_sticky", ferr, 1);
        drain("t5");

        // Test 6: reset while three words are stuck behind a stalled sink
        do_reset();
        m_ready = 1'b0;
        vec(1, d, w); send(d, w, 1'b1, "t6_a");
        vec(2, d, w); send(d, w, 1'b0, "t6_b");
        vec(3, d, w); send(d, w, 1'b0, "t6_c");
        cyc();
        chk("t6_pre_valid", m_valid, 1);
        chk("t6_pre_last", m_last, 1);
        chk("t6_pre_err", ferr, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_last", m_last, 0);
        chk("t6_rst_data", data_o, 0);
        chk("t6_rst_err", ferr, 0);
        chk("t6_rst_s_ready", s_ready, 0);
        @(negedge clk);
        cyc();
        rstn    = 1'b1;
        m_ready = 1'b1;
        vec(20, d, w);
        send_lat(d, w, 1'b0, '0, 0, "t6_fresh");
        for (int k = 21; k < 24; k++) begin
            vec(k, d, w);
            send(d, w, (k == 23), "t6_frame");
        end
        drain("t6");
        chk("t6_frame_err", ferr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
